gate_pipe: RTL
==============

GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits (legal values 1..64).
REQ-002 Parameter CNT_W, default 16, sets the width of the accepted-beat counter.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  upstream beat valid.
REQ-006 o_ready  output  1  block can accept a beat this cycle.
REQ-007 i_a, i_b  input  WIDTH each  operands.
REQ-008 i_op  input  3  operation select, sampled with the beat.
REQ-009 i_last  input  1  final beat of an accumulate sequence; ignored for ops 0-6.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  downstream accepts the result.
REQ-012 o_c  output  WIDTH  registered result.
REQ-013 o_zero  output  1  registered flag, high when o_c == 0.
REQ-014 o_op  output  3  op code that produced o_c.
REQ-015 o_count  output  CNT_W  number of accepted input beats.
REQ-016 o_err  output  1  sticky flag for an aborted accumulate sequence.

Function
REQ-017 Input transfer SHALL occur when i_valid && o_ready; output transfer SHALL occur when o_valid && i_ready.
REQ-018 o_ready SHALL equal !o_valid || i_ready (combinational; full throughput, one beat per cycle).
REQ-019 Ops: 0 AND, 1 OR, 2 NOR, 3 XOR, 4 NAND, 5 XNOR, 6 NOT i_a, 7 ACC (running XOR of i_a & i_b), all bitwise over WIDTH.
REQ-020 Ops 0-6: result SHALL appear on o_c with o_valid high in the cycle after transfer (latency 1).
REQ-021 o_c, o_zero, o_op SHALL hold stable while o_valid && !i_ready.
REQ-022 o_valid SHALL fall after an output transfer unless a new result loads in the same cycle.
REQ-023 Accumulate FSM states: IDLE, ACCUM; accumulator acc is WIDTH bits.
REQ-024 IDLE, op 7, i_last=0: acc <= i_a & i_b; go to ACCUM; no output produced.
REQ-025 IDLE, op 7, i_last=1: single-beat sequence; o_c <= i_a & i_b next cycle; stay in IDLE.
REQ-026 ACCUM, op 7, i_last=0: acc <= acc ^ (i_a & i_b); stay in ACCUM; no output produced.
REQ-027 ACCUM, op 7, i_last=1: o_c <= acc ^ (i_a & i_b), o_op=7 next cycle; acc cleared; go to IDLE.
REQ-028 ACCUM, op 0-6 beat: partial acc discarded; o_err set; the beat processed as a normal op; go to IDLE.
REQ-029 No transfer cycles SHALL leave FSM and acc unchanged.
REQ-030 o_count SHALL increment by 1 per input transfer, including non-emitting accumulate beats.
REQ-031 o_count SHALL saturate at all-ones; no wrap.
REQ-032 o_err SHALL remain high until reset.

Reset
REQ-033 While i_rst_n=0: o_valid=0, o_c=0, o_zero=1, o_op=0, o_count=0, o_err=0, acc=0, FSM=IDLE, independent of i_clk.
REQ-034 o_ready SHALL be 1 during reset (follows REQ-018 with o_valid=0), but no transfer is recorded.
REQ-035 Reset asserted mid-sequence SHALL drop any pending result and partial accumulation; first beat after release starts in IDLE.

Verification
REQ-036 WIDTH=8, a=0xF0, b=0xCC, ops 0..6 back-to-back, i_ready=1 -> o_c 0xC0,0xFC,0x03,0x3C,0x3F,0xC3,0x0F on consecutive cycles, latency 1, o_count=7.
REQ-037 Op 7 beats (0xFF,0x0F),(0xFF,0x3C),(0xFF,0x01,last) -> single result o_c=0x32, o_op=7, o_zero=0, o_count=3.
REQ-038 Result pending with i_ready=0 for 5 cycles -> o_c/o_valid held, o_ready=0, no input accepted; release -> drains in order, no loss or duplication.
REQ-039 Op 7 beat (non-last), then op 0 a=0x0F, b=0x0F -> o_err=1, o_c=0x0F, FSM IDLE; next op 7 last (0x01,0x01) -> o_c=0x01.
REQ-040 CNT_W=4, 20 beats -> o_count stops at 0xF; a=0xAA, b=0x55 op 0 -> o_c=0x00, o_zero=1.
REQ-041 Assert i_rst_n=0 between edges during ACCUM with o_valid=1 -> immediate reset values per REQ-033; post-release op 7 last (0x03,0x01) -> o_c=0x01.

Source files
------------

// File: rtl/gate_pipe.sv
// Bitwise-logic pipeline with a one-deep registered output stage and an
// XOR-accumulate sequence mode (op 7), plus a saturating accepted-beat counter.
module gate_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_c,
    output logic             o_zero,
    output logic [2:0]       o_op,
    output logic [CNT_W-1:0] o_count,
    output logic             o_err
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_ACC  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] res;
    logic             in_xfer;
    logic             out_xfer;
    logic             emit;
    logic             err_d;
    logic             valid_d;

    // Output stage may be refilled in the same cycle it drains.
    assign o_ready  = !o_valid || i_ready;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state, accumulator and result selection.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        emit      = 1'b0;
        res       = '0;
        err_d     = o_err;
        ab        = i_a & i_b;
        logic_res = '0;

        case (i_op)
            OP_AND:  logic_res = i_a & i_b;
            OP_OR:   logic_res = i_a | i_b;
            OP_NOR:  logic_res = ~(i_a | i_b);
            OP_XOR:  logic_res = i_a ^ i_b;
            OP_NAND: logic_res = ~(i_a & i_b);
            OP_XNOR: logic_res = ~(i_a ^ i_b);
            OP_NOT:  logic_res = ~i_a;
            default: logic_res = '0;
        endcase

        if (in_xfer) begin
            if (i_op == OP_ACC) begin
                if (state_q == IDLE) begin
                    if (i_last) begin
                        emit = 1'b1;
                        res  = ab;
                    end else begin
                        acc_d   = ab;
                        state_d = ACCUM;
                    end
                end else begin
                    if (i_last) begin
                        emit    = 1'b1;
                        res     = acc_q ^ ab;
                        acc_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = acc_q ^ ab;
                    end
                end
            end else begin
                emit = 1'b1;
                res  = logic_res;
                // A plain op in the middle of a sequence aborts it.
                if (state_q == ACCUM) begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
        end

        if (emit) begin
            valid_d = 1'b1;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end else begin
            valid_d = o_valid;
        end
    end

    // Registered result stage, error flag and beat counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_c     <= '0;
            o_zero  <= 1'b1;
            o_op    <= 3'd0;
            o_count <= '0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= valid_d;
            o_err   <= err_d;
            if (emit) begin
                o_c    <= res;
                o_zero <= (res == '0);
                o_op   <= i_op;
            end
            if (in_xfer && (o_count != '1)) begin
                o_count <= o_count + CNT_W'(1);
            end
        end
    end

endmodule
